// File: rtl/hamming_secded_decoder.sv
// Two-stage pipelined extended-Hamming (SECDED) decoder with
// valid/ready flow control and saturating error counters.
module hamming_secded_decoder #(
   parameter int DATA_WIDTH = 32,
   parameter int COUNT_WIDTH = 16,
   localparam int ADDR_WIDTH =
      (DATA_WIDTH <= 4)   ? 3 :
      (DATA_WIDTH <= 11)  ? 4 :
      (DATA_WIDTH <= 26)  ? 5 :
      (DATA_WIDTH <= 57)  ? 6 :
      (DATA_WIDTH <= 120) ? 7 :
      (DATA_WIDTH <= 247) ? 8 :
      (DATA_WIDTH <= 502) ? 9 : 10,
   localparam int CODED_WIDTH = 2 ** ADDR_WIDTH
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   input  logic [CODED_WIDTH-1:0] code_i,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [DATA_WIDTH-1:0]  data_o,
   output logic                   single_err_o,
   output logic                   double_err_o,
   output logic [ADDR_WIDTH-1:0]  err_pos_o,
   input  logic                   clr_counts_i,
   output logic [COUNT_WIDTH-1:0] corr_count_o,
   output logic [COUNT_WIDTH-1:0] uncorr_count_o
);

   // Codeword position carrying payload bit j: the j-th
   // non-power-of-two index starting at 3.
   function automatic int pos_of(input int j);
      int k;
      int p;
      k = 0;
      p = 0;
      for (int i = 3; i < CODED_WIDTH; i++) begin
         if ((i & (i - 1)) != 0) begin
            if (k == j) p = i;
            k = k + 1;
         end
      end
      return p;
   endfunction

   logic                   s1_valid_q;
   logic [CODED_WIDTH-1:0] s1_code_q;
   logic                   s2_valid_q;
   logic [DATA_WIDTH-1:0]  s2_data_q;
   logic                   s2_single_q;
   logic                   s2_double_q;
   logic [ADDR_WIDTH-1:0]  s2_pos_q;
   logic [COUNT_WIDTH-1:0] corr_q;
   logic [COUNT_WIDTH-1:0] uncorr_q;

   logic                   s1_load;
   logic                   s2_load;
   logic                   deliver;
   logic [ADDR_WIDTH-1:0]  syn_d;
   logic                   par_d;
   logic [CODED_WIDTH-1:0] fix_code_d;
   logic [DATA_WIDTH-1:0]  data_d;
   logic                   single_d;
   logic                   double_d;
   logic [ADDR_WIDTH-1:0]  pos_d;

   assign s2_load    = !s2_valid_q || out_ready_i;
   assign s1_load    = !s1_valid_q || s2_load;
   assign in_ready_o = s1_load;
   assign deliver    = s2_valid_q && out_ready_i;

   // Syndrome is the XOR of indices of set bits; P is overall parity.
   always_comb begin
      syn_d = '0;
      par_d = ^s1_code_q;
      for (int i = 1; i < CODED_WIDTH; i++) begin
         if (s1_code_q[i]) syn_d = syn_d ^ ADDR_WIDTH'(i);
      end
   end

   // Classify the error and repair a single flipped bit in place.
   always_comb begin
      fix_code_d = s1_code_q;
      single_d   = 1'b0;
      double_d   = 1'b0;
      pos_d      = '0;
      if (par_d) begin
         single_d = 1'b1;
         if (syn_d != '0) begin
            fix_code_d[syn_d] = ~s1_code_q[syn_d];
            pos_d = syn_d;
         end
      end else if (syn_d != '0) begin
         double_d = 1'b1;
      end
   end

   for (genvar j = 0; j < DATA_WIDTH; j++) begin : g_extract
      assign data_d[j] = fix_code_d[pos_of(j)];
   end

   // Stage 1: capture the incoming codeword on accept.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_valid_q <= 1'b0;
         s1_code_q  <= '0;
      end else if (s1_load) begin
         s1_valid_q <= in_valid_i;
         s1_code_q  <= code_i;
      end
   end

   // Stage 2: register the decoded result; holds under backpressure.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s2_valid_q  <= 1'b0;
         s2_data_q   <= '0;
         s2_single_q <= 1'b0;
         s2_double_q <= 1'b0;
         s2_pos_q    <= '0;
      end else if (s2_load) begin
         s2_valid_q  <= s1_valid_q;
         s2_data_q   <= data_d;
         s2_single_q <= single_d;
         s2_double_q <= double_d;
         s2_pos_q    <= pos_d;
      end
   end

   // Saturating error counters, bumped only when a result is taken.
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_counts_i) begin
         corr_q   <= '0;
         uncorr_q <= '0;
      end else if (deliver) begin
         if (s2_single_q && (corr_q != '1))
            corr_q <= corr_q + COUNT_WIDTH'(1);
         if (s2_double_q && (uncorr_q != '1))
            uncorr_q <= uncorr_q + COUNT_WIDTH'(1);
      end
   end

   assign out_valid_o    = s2_valid_q;
   assign data_o         = s2_data_q;
   assign single_err_o   = s2_single_q;
   assign double_err_o   = s2_double_q;
   assign err_pos_o      = s2_pos_q;
   assign corr_count_o   = corr_q;
   assign uncorr_count_o = uncorr_q;

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Scoreboard bench for hamming_secded_decoder: random and directed
// codewords checked against an encoder/injection reference model.
module tb_hamming_secded_decoder;

   localparam int DW   = 32;
   localparam int CNTW = 2;
   localparam int AW   = 6;
   localparam int CW   = 64;

   logic            clk = 1'b0;
   logic            rst_i = 1'b1;
   logic            in_valid_i = 1'b0;
   logic            in_ready_o;
   logic [CW-1:0]   code_i = '0;
   logic            out_valid_o;
   logic            out_ready_i = 1'b1;
   logic [DW-1:0]   data_o;
   logic            single_err_o;
   logic            double_err_o;
   logic [AW-1:0]   err_pos_o;
   logic            clr_counts_i = 1'b0;
   logic [CNTW-1:0] corr_count_o;
   logic [CNTW-1:0] uncorr_count_o;

   typedef struct {
      logic [DW-1:0] data;
      logic          single;
      logic          dbl;
      logic [AW-1:0] pos;
   } exp_t;

   exp_t            q[$];
   int              errors = 0;
   int              checks = 0;
   logic [CNTW-1:0] corr_m = '0;
   logic [CNTW-1:0] unc_m = '0;
   bit              bp_en = 1'b0;

   hamming_secded_decoder #(.DATA_WIDTH(DW), .COUNT_WIDTH(CNTW)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .code_i(code_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .data_o(data_o),
      .single_err_o(single_err_o), .double_err_o(double_err_o),
      .err_pos_o(err_pos_o),
      .clr_counts_i(clr_counts_i),
      .corr_count_o(corr_count_o), .uncorr_count_o(uncorr_count_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic bit is_pow2(input int i);
      return (i & (i - 1)) == 0;
   endfunction

   // Reference encoder: payload on non-power-of-two slots, then
   // even parity per power-of-two group, then overall parity.
   function automatic logic [CW-1:0] encode(input logic [DW-1:0] d);
      logic [CW-1:0] c;
      int k;
      logic par;
      c = '0;
      k = 0;
      for (int i = 1; i < CW; i++) begin
         if (!is_pow2(i)) begin
            if (k < DW) c[i] = d[k];
            k++;
         end
      end
      for (int p = 1; p < CW; p = p * 2) begin
         par = 1'b0;
         for (int i = 1; i < CW; i++)
            if (((i & p) != 0) && (i != p)) par = par ^ c[i];
         c[p] = par;
      end
      c[0] = ^c[CW-1:1];
      return c;
   endfunction

   function automatic logic [DW-1:0] extract(input logic [CW-1:0] c);
      logic [DW-1:0] d;
      int k;
      d = '0;
      k = 0;
      for (int i = 1; i < CW; i++) begin
         if (!is_pow2(i)) begin
            if (k < DW) d[k] = c[i];
            k++;
         end
      end
      return d;
   endfunction

   // Expected result follows directly from what was injected.
   task automatic gen(input logic [DW-1:0] d, input int nflip,
                      input int a, input int b,
                      output logic [CW-1:0] c, output exp_t e);
      c = encode(d);
      if (nflip >= 1) c[a] = ~c[a];
      if (nflip == 2) c[b] = ~c[b];
      e.data   = (nflip == 2) ? extract(c) : d;
      e.single = (nflip == 1);
      e.dbl    = (nflip == 2);
      e.pos    = (nflip == 1) ? AW'(a) : '0;
   endtask

   // Present a word and push its expectation once accepted.
   task automatic send(input logic [CW-1:0] c, input exp_t e);
      int n;
      n = 0;
      in_valid_i = 1'b1;
      code_i = c;
      @(negedge clk);
      while (!in_ready_o && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready_o) begin
         chk("accept_timeout", 64'(in_ready_o), 64'd1);
      end else begin
         q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_gen(input logic [DW-1:0] d, input int nflip,
                           input int a, input int b);
      logic [CW-1:0] c;
      exp_t e;
      gen(d, nflip, a, b, c, e);
      send(c, e);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   // Random backpressure when enabled.
   always @(posedge clk) begin
      if (bp_en) begin
         #1;
         out_ready_i = ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: pops and compares each delivered result, tracks counters.
   always @(negedge clk) begin
      exp_t e;
      bit   hs;
      bit   got;
      got = 1'b0;
      if (rst_i) begin
         q.delete();
         corr_m = '0;
         unc_m = '0;
      end else begin
         chk("corr_count", 64'(corr_count_o), 64'(corr_m));
         chk("uncorr_count", 64'(uncorr_count_o), 64'(unc_m));
         hs = out_valid_o && out_ready_i;
         if (hs) begin
            if (q.size() == 0) begin
               chk("unexpected_output", 64'(out_valid_o), 64'd0);
            end else begin
               e = q.pop_front();
               got = 1'b1;
               chk("data", 64'(data_o), 64'(e.data));
               chk("single_err", 64'(single_err_o), 64'(e.single));
               chk("double_err", 64'(double_err_o), 64'(e.dbl));
               chk("err_pos", 64'(err_pos_o), 64'(e.pos));
            end
         end
         if (clr_counts_i) begin
            corr_m = '0;
            unc_m = '0;
         end else if (got) begin
            if (e.single && corr_m != '1) corr_m = corr_m + 1'b1;
            if (e.dbl && unc_m != '1) unc_m = unc_m + 1'b1;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [CW-1:0] c;
      exp_t ea;
      exp_t ec;
      int a;
      int b;
      int k;

      repeat (3) @(posedge clk);
      #1;
      rst_i = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid_o), 64'd0);
      chk("rst_data", 64'(data_o), 64'd0);
      chk("rst_flags", {single_err_o, double_err_o}, 64'd0);
      chk("rst_pos", 64'(err_pos_o), 64'd0);
      chk("rst_in_ready", 64'(in_ready_o), 64'd1);
      @(posedge clk);
      #1;

      // All-zero codeword and its two-cycle latency.
      send_gen('0, 0, 0, 0);
      in_valid_i = 1'b0;
      @(negedge clk);
      chk("lat_cycle1_valid", 64'(out_valid_o), 64'd0);
      @(negedge clk);
      chk("lat_cycle2_valid", 64'(out_valid_o), 64'd1);
      drain();

      send_gen(32'hDEADBEEF, 1, 37, 0);
      send_gen(32'hDEADBEEF, 1, 0, 0);
      send_gen('0, 2, 3, 5);
      in_valid_i = 1'b0;
      drain();
      chk("dir_corr_count", 64'(corr_count_o), 64'd2);
      chk("dir_uncorr_count", 64'(uncorr_count_o), 64'd1);

      // Backpressure: two accepted, third stalls, then all drain.
      out_ready_i = 1'b0;
      gen($urandom, 0, 0, 0, c, ea);
      send(c, ea);
      send_gen($urandom, 1, 11, 0);
      gen($urandom, 1, 50, 0, c, ec);
      in_valid_i = 1'b1;
      code_i = c;
      repeat (2) begin
         @(negedge clk);
         chk("bp_in_ready_low", 64'(in_ready_o), 64'd0);
         chk("bp_hold_valid", 64'(out_valid_o), 64'd1);
         chk("bp_hold_data", 64'(data_o), 64'(ea.data));
      end
      @(posedge clk);
      #1;
      out_ready_i = 1'b1;
      @(negedge clk);
      chk("bp_release_ready", 64'(in_ready_o), 64'd1);
      chk("bp_consec_1", 64'(out_valid_o), 64'd1);
      if (in_ready_o) q.push_back(ec);
      @(posedge clk);
      #1;
      in_valid_i = 1'b0;
      @(negedge clk);
      chk("bp_consec_2", 64'(out_valid_o), 64'd1);
      @(negedge clk);
      chk("bp_consec_3", 64'(out_valid_o), 64'd1);
      drain();

      // Saturation at 3 and clear on a delivering cycle.
      clr_counts_i = 1'b1;
      @(posedge clk);
      #1;
      clr_counts_i = 1'b0;
      for (int i = 0; i < 5; i++)
         send_gen($urandom, 1, $urandom_range(1, CW - 1), 0);
      in_valid_i = 1'b0;
      drain();
      chk("sat_corr_count", 64'(corr_count_o), 64'd3);
      send_gen($urandom, 1, 9, 0);
      in_valid_i = 1'b0;
      @(posedge clk);
      #1;
      clr_counts_i = 1'b1;
      @(negedge clk);
      chk("clr_on_deliver_valid", 64'(out_valid_o), 64'd1);
      @(posedge clk);
      #1;
      clr_counts_i = 1'b0;
      @(negedge clk);
      chk("clr_priority", 64'(corr_count_o), 64'd0);
      drain();

      // Reset with two words in flight.
      send_gen($urandom, 1, 6, 0);
      send_gen($urandom, 2, 7, 12);
      in_valid_i = 1'b0;
      drain();
      out_ready_i = 1'b0;
      send_gen($urandom, 0, 0, 0);
      send_gen($urandom, 1, 20, 0);
      in_valid_i = 1'b0;
      rst_i = 1'b1;
      @(posedge clk);
      #1;
      rst_i = 1'b0;
      out_ready_i = 1'b1;
      @(negedge clk);
      chk("rst_mid_valid", 64'(out_valid_o), 64'd0);
      chk("rst_mid_corr", 64'(corr_count_o), 64'd0);
      chk("rst_mid_uncorr", 64'(uncorr_count_o), 64'd0);
      repeat (4) begin
         @(negedge clk);
         chk("rst_no_stale", 64'(out_valid_o), 64'd0);
      end
      @(posedge clk);
      #1;

      // Randomized traffic with backpressure and sporadic clears.
      bp_en = 1'b1;
      for (int i = 0; i < 400; i++) begin
         k = $urandom_range(0, 2);
         a = $urandom_range(0, CW - 1);
         b = (a + $urandom_range(1, CW - 1)) % CW;
         clr_counts_i = ($urandom_range(0, 15) == 0);
         send_gen($urandom, k, a, b);
         clr_counts_i = 1'b0;
         if ($urandom_range(0, 3) == 0) begin
            in_valid_i = 1'b0;
            @(posedge clk);
            #1;
         end
      end
      in_valid_i = 1'b0;
      drain();
      bp_en = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      out_ready_i = 1'b1;
      repeat (3) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
